// File: rtl/mp_add_seq_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mp_add_state_t;

    // Word-index width; a single-word operand still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Start/result handshake and operand/result bus of mp_add_seq.
// Both handshakes transfer on a rising clock edge where valid && ready; the
// sender must hold valid and its payload until that edge, and the receiver
// may raise or drop ready freely.
interface mp_add_seq_if
    import mp_add_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_WORDS  = 4
);
    localparam int TOTAL_W = DATA_WIDTH * NUM_WORDS;

    logic               start_valid_in;
    logic               start_ready_out;
    logic [TOTAL_W-1:0] a_in;
    logic [TOTAL_W-1:0] b_in;
    logic               carry_in;
    logic               sub_in;
    logic [TOTAL_W-1:0] sum_out;
    logic               carry_out;
    logic               overflow_out;
    logic               done_valid_out;
    logic               done_ready_in;
    logic               busy_out;
    mp_add_state_t      state_dbg;
    logic               sub_mode_dbg;

    modport slave (
        input  start_valid_in, a_in, b_in, carry_in, sub_in, done_ready_in,
        output start_ready_out, sum_out, carry_out, overflow_out,
               done_valid_out, busy_out, state_dbg, sub_mode_dbg
    );

    modport master (
        output start_valid_in, a_in, b_in, carry_in, sub_in, done_ready_in,
        input  start_ready_out, sum_out, carry_out, overflow_out,
               done_valid_out, busy_out, state_dbg, sub_mode_dbg
    );

endinterface

// File: rtl/carry_look_ahead_adder.sv
// Purely combinational DATA_WIDTH-bit carry-lookahead adder; every carry is a
// flat sum-of-products of generate/propagate terms and the carry input.
module carry_look_ahead_adder #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  carry_in,
    output logic [DATA_WIDTH-1:0] sum_out,
    output logic                  carry_out
);

    logic [DATA_WIDTH-1:0] gen;
    logic [DATA_WIDTH-1:0] prop;
    logic [DATA_WIDTH:0]   carry;
    logic                  acc;
    logic                  prod;

    assign gen  = a_in & b_in;
    assign prop = a_in ^ b_in;

    // carry[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
    always_comb begin
        carry    = '0;
        acc      = 1'b0;
        prod     = 1'b0;
        carry[0] = carry_in;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            acc  = gen[i];
            prod = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & gen[j]);
                prod = prod & prop[j];
            end
            carry[i+1] = acc | (prod & carry_in);
        end
    end

    assign sum_out   = prop ^ carry[DATA_WIDTH-1:0];
    assign carry_out = carry[DATA_WIDTH];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: one DATA_WIDTH-bit adder walked over NUM_WORDS
// words, least-significant first, with the inter-word carry held in a register.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_WORDS  = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    mp_add_seq_if.slave bus
);

    localparam int TOTAL_W = DATA_WIDTH * NUM_WORDS;
    localparam int IDX_W   = clog2_min1(NUM_WORDS);

    localparam logic [1:0]       S_IDLE   = IDLE;
    localparam logic [1:0]       S_RUN    = RUN;
    localparam logic [1:0]       S_DONE   = DONE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [1:0]         state_q, state_d;
    logic [TOTAL_W-1:0] op_a_q, op_a_d;
    logic [TOTAL_W-1:0] op_b_q, op_b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sub_q, sub_d;
    logic [TOTAL_W-1:0] sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] word_a;
    logic [DATA_WIDTH-1:0] word_b;
    logic [DATA_WIDTH-1:0] word_sum;
    logic                  word_cout;
    logic                  last_word;

    assign word_a    = op_a_q[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];
    assign word_b    = op_b_q[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];
    assign last_word = (idx_q == LAST_IDX);

    carry_look_ahead_adder #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cla (
        .a_in      (word_a),
        .b_in      (word_b),
        .carry_in  (carry_q),
        .sum_out   (word_sum),
        .carry_out (word_cout)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_valid_in) begin
                    // Subtraction is A + ~B + 1: invert B once here, seed carry with 1.
                    op_a_d  = bus.a_in;
                    op_b_d  = bus.sub_in ? ~bus.b_in : bus.b_in;
                    carry_d = bus.sub_in ? 1'b1 : bus.carry_in;
                    idx_d   = '0;
                    sub_d   = bus.sub_in;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH] = word_sum;
                carry_d = word_cout;
                if (last_word) begin
                    cout_d  = word_cout;
                    ovf_d   = (op_a_q[TOTAL_W-1] == op_b_q[TOTAL_W-1]) &&
                              (word_sum[DATA_WIDTH-1] != op_a_q[TOTAL_W-1]);
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.done_ready_in) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.start_ready_out = (state_q == S_IDLE);
    assign bus.done_valid_out  = (state_q == S_DONE);
    assign bus.busy_out        = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus.sum_out         = sum_q;
    assign bus.carry_out       = cout_q;
    assign bus.overflow_out    = ovf_q;
    assign bus.state_dbg       = mp_add_state_t'(state_q);
    assign bus.sub_mode_dbg    = sub_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (DATA_WIDTH=4, NUM_WORDS=4) against a
// whole-operand integer model of add, subtract, carry and signed overflow.
module tb_mp_add_seq;
    import mp_add_pkg::*;

    localparam int DW = 4;
    localparam int NW = 4;
    localparam int TW = DW * NW;
    localparam int W  = TW + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    mp_add_seq_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) bus ();

    mp_add_seq #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {overflow, carry, sum} from plain integer arithmetic on the full operands.
    function automatic logic [W-1:0] model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                           input logic cin, input logic sub);
        int unsigned ua, ub, ures;
        int sa, sb, sres;
        logic c;
        logic ovf;
        logic [TW-1:0] s;
        ua = {16'h0, a};
        ub = {16'h0, b};
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ures = ua - ub;
            c    = (ua >= ub);
            sres = sa - sb;
        end else begin
            ures = ua + ub + {31'h0, cin};
            c    = ures[TW];
            sres = sa + sb + int'({31'h0, cin});
        end
        s   = ures[TW-1:0];
        ovf = (sres > 32767) || (sres < -32768);
        return {ovf, c, s};
    endfunction

    function automatic logic [W-1:0] observed();
        return {bus.overflow_out, bus.carry_out, bus.sum_out};
    endfunction

    task automatic start_op(input logic [TW-1:0] a, input logic [TW-1:0] b,
                            input logic cin, input logic sub);
        @(negedge clk);
        bus.start_valid_in = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.carry_in = cin;
        bus.sub_in   = sub;
        total++;
        if (bus.start_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL start_ready before accept: got %b want 1", bus.start_ready_out);
        end
        exp_q.push_back(model(a, b, cin, sub));
        @(posedge clk);
        #1;
        // Scramble operands after the accept edge; the result must not change.
        bus.start_valid_in = 1'b0;
        bus.a_in     = TW'($urandom);
        bus.b_in     = TW'($urandom);
        bus.carry_in = 1'($urandom);
        bus.sub_in   = 1'($urandom);
        total++;
        if (bus.busy_out !== 1'b1) begin
            bad++;
            $display("FAIL busy after accept: got %b want 1", bus.busy_out);
        end
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (cyc < 20 && bus.done_valid_out !== 1'b1) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        total++;
        if (cyc != NW || bus.done_valid_out !== 1'b1) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles (done=%b) want %0d", name, cyc,
                     bus.done_valid_out, NW);
        end
    endtask

    task automatic check_result(input string name);
        logic [W-1:0] exp;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s result: no expected entry queued", name);
        end else begin
            exp = exp_q.pop_front();
            if (observed() !== exp) begin
                bad++;
                $display("FAIL %s result: got ovf=%b c=%b sum=%h want ovf=%b c=%b sum=%h", name,
                         bus.overflow_out, bus.carry_out, bus.sum_out,
                         exp[W-1], exp[W-2], exp[TW-1:0]);
            end
        end
    endtask

    task automatic finish_op(input string name);
        @(negedge clk);
        bus.done_ready_in = 1'b1;
        @(posedge clk);
        #1;
        bus.done_ready_in = 1'b0;
        total++;
        if (bus.done_valid_out !== 1'b0 || bus.start_ready_out !== 1'b1 || bus.busy_out !== 1'b0) begin
            bad++;
            $display("FAIL %s release: got done=%b ready=%b busy=%b want 0 1 0", name,
                     bus.done_valid_out, bus.start_ready_out, bus.busy_out);
        end
    endtask

    task automatic test_reset();
        bus.start_valid_in = 1'b0;
        bus.done_ready_in  = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.carry_in = 1'b0;
        bus.sub_in   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.sum_out !== '0) begin bad++; $display("FAIL reset sum: got %h want 0", bus.sum_out); end
        total++;
        if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL reset carry: got %b want 0", bus.carry_out); end
        total++;
        if (bus.overflow_out !== 1'b0) begin bad++; $display("FAIL reset ovf: got %b want 0", bus.overflow_out); end
        total++;
        if (bus.done_valid_out !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", bus.done_valid_out); end
        total++;
        if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", bus.busy_out); end
        total++;
        if (bus.start_ready_out !== 1'b1) begin bad++; $display("FAIL reset ready: got %b want 1", bus.start_ready_out); end
    endtask

    task automatic test_directed();
        logic [TW-1:0] va[5] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0005, 16'h8000};
        logic [TW-1:0] vb[5] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0007, 16'h0001};
        logic          vc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic          vs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i], vc[i], vs[i]);
            wait_done($sformatf("directed%0d", i));
            check_result($sformatf("directed%0d", i));
            finish_op($sformatf("directed%0d", i));
        end
    endtask

    task automatic test_random();
        int hold;
        for (int i = 0; i < 25; i++) begin
            start_op(TW'($urandom), TW'($urandom), 1'($urandom), 1'($urandom));
            wait_done($sformatf("random%0d", i));
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                total++;
                if (bus.done_valid_out !== 1'b1 || observed() !== exp_q[0]) begin
                    bad++;
                    $display("FAIL random%0d hold: got done=%b res=%h want 1 %h", i,
                             bus.done_valid_out, observed(), exp_q[0]);
                end
            end
            check_result($sformatf("random%0d", i));
            finish_op($sformatf("random%0d", i));
        end
    endtask

    task automatic test_backpressure();
        logic [TW-1:0] na, nb;
        logic          nc, ns;
        start_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b0);
        wait_done("bp");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.start_valid_in = 1'b1;
            bus.a_in = TW'($urandom);
            bus.b_in = TW'($urandom);
            bus.sub_in = 1'($urandom);
            @(posedge clk);
            #1;
            total++;
            if (observed() !== exp_q[0] || bus.start_ready_out !== 1'b0 || bus.done_valid_out !== 1'b1) begin
                bad++;
                $display("FAIL bp stall%0d: got res=%h ready=%b done=%b want %h 0 1", k,
                         observed(), bus.start_ready_out, bus.done_valid_out, exp_q[0]);
            end
        end
        check_result("bp");
        na = TW'($urandom);
        nb = TW'($urandom);
        nc = 1'($urandom);
        ns = 1'($urandom);
        @(negedge clk);
        bus.done_ready_in = 1'b1;
        bus.a_in = na;
        bus.b_in = nb;
        bus.carry_in = nc;
        bus.sub_in = ns;
        @(posedge clk);
        #1;
        bus.done_ready_in = 1'b0;
        total++;
        if (bus.done_valid_out !== 1'b0 || bus.start_ready_out !== 1'b1 || bus.busy_out !== 1'b0) begin
            bad++;
            $display("FAIL bp handshake: got done=%b ready=%b busy=%b want 0 1 0",
                     bus.done_valid_out, bus.start_ready_out, bus.busy_out);
        end
        exp_q.push_back(model(na, nb, nc, ns));
        @(posedge clk);
        #1;
        bus.start_valid_in = 1'b0;
        total++;
        if (bus.busy_out !== 1'b1 || bus.start_ready_out !== 1'b0) begin
            bad++;
            $display("FAIL bp next accept: got busy=%b ready=%b want 1 0", bus.busy_out, bus.start_ready_out);
        end
        wait_done("bp_next");
        check_result("bp_next");
        finish_op("bp_next");
    endtask

    task automatic test_reset_mid();
        start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        total++;
        if (observed() !== '0) begin bad++; $display("FAIL midreset outputs: got %h want 0", observed()); end
        total++;
        if (bus.busy_out !== 1'b0 || bus.done_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL midreset busy/done: got %b %b want 0 0", bus.busy_out, bus.done_valid_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.start_ready_out !== 1'b1 || bus.done_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL midreset release: got ready=%b done=%b want 1 0", bus.start_ready_out, bus.done_valid_out);
        end
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done("post_reset");
        check_result("post_reset");
        finish_op("post_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer. Adds two operands of NUM_WORDS*DATA_WIDTH bits using a single carry_look_ahead_adder instance of DATA_WIDTH bits.
- Processes one word per clock, least-significant word first, and carries the inter-word carry in a register.
- Sits between a requester using a valid/ready start handshake and a consumer using a valid/ready result handshake.
- Lets narrow adder hardware serve wide arithmetic.

Parameters:
DATA_WIDTH, 4, width of the shared carry_look_ahead_adder word
NUM_WORDS, 4, number of words per operand (>=1); total width TOTAL_W = DATA_WIDTH*NUM_WORDS

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
start_valid_in  input  1  requester has an operation
start_ready_out  output  1  block can accept (high only in IDLE)
a_in  input  TOTAL_W  operand A
b_in  input  TOTAL_W  operand B
carry_in  input  1  carry into word 0 (add mode only)
sub_in  input  1  1 = A-B, 0 = A+B+carry_in
sum_out  output  TOTAL_W  result
carry_out  output  1  carry out of MSB word (sub: 1 = no borrow)
overflow_out  output  1  two's-complement signed overflow
done_valid_out  output  1  result valid
done_ready_in  input  1  consumer takes result
busy_out  output  1  high in RUN or DONE

Behaviour:
- Reset: the one clock is clk_in; reset is rst_n_in, asynchronous, active-low. It is asserted asynchronously and released synchronously to clk_in by the environment. On reset: state=IDLE; sum_out=0; carry_out=0; overflow_out=0; done_valid_out=0; busy_out=0; start_ready_out=1 once reset deasserts; internal index, carry and operand registers are 0.
- States: IDLE, RUN, DONE.
- IDLE, on the accept edge (start_valid_in && start_ready_out):
  - Register A into op_a. Register B into op_b, with B inverted when sub_in=1.
  - Carry register = sub_in ? 1 : carry_in.
  - idx=0; latch sub_in. Go to RUN.
- IDLE, without start_valid_in: stay in IDLE.
- RUN, each cycle:
  - Drive the adder with op_a word[idx], op_b word[idx] and the carry register.
  - Write the adder sum into sum word[idx]; carry register <= adder carry_out; idx++.
  - When idx==NUM_WORDS-1: capture carry_out; compute overflow_out; go to DONE.
- Overflow: overflow_out = (a_msb == b_eff_msb) && (sum_msb != a_msb), using the effective (possibly inverted) B.
- Latency: done_valid_out rises NUM_WORDS cycles after the accept edge. NUM_WORDS=1 gives one RUN cycle.
- DONE:
  - done_valid_out=1. sum_out, carry_out and overflow_out are held stable.
  - Leave to IDLE on done_valid_out && done_ready_in.
  - No bypass: a new start is accepted no earlier than the cycle after the handshake.
- Backpressure: DONE holds indefinitely while done_ready_in=0.
- start_valid_in outside IDLE: ignored, because start_ready_out=0. a_in, b_in, carry_in and sub_in are sampled only on the accept edge; later changes have no effect.
- sum_out: holds the last result until the next accept. Words are updated in place during RUN, so sum_out is valid only while done_valid_out=1.
- Reset mid-RUN or mid-DONE: the operation is aborted and all outputs return to their reset values immediately, with no result emitted.
- idx width: $clog2(NUM_WORDS), minimum 1. idx never exceeds NUM_WORDS-1.
- Adder: used combinationally only. No registered path inside it.

Decomposition:
- Package mp_add_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mp_add_state_t
  - function clog2_min1 for the idx width
- Sub-module: the existing carry_look_ahead_adder #(.DATA_WIDTH(DATA_WIDTH)), instantiated once.
- The FSM, word mux, operand registers and result registers live in mp_add_seq.

Test Plan:
(DATA_WIDTH=4, NUM_WORDS=4, TOTAL_W=16)
- A=0x0000, B=0x0000, cin=0, add -> sum=0x0000, carry=0, ovf=0; done_valid_out rises exactly 4 cycles after the accept edge.
- A=0xFFFF, B=0x0001, cin=0, add -> sum=0x0000, carry=1, ovf=0. Carry ripples through all 4 words.
- A=0xFFFF, B=0xFFFF, cin=1, add -> sum=0xFFFF, carry=1, ovf=0.
- Subtraction:
  - A=0x0005, B=0x0007, sub -> sum=0xFFFE, carry=0 (borrow), ovf=0.
  - A=0x8000, B=0x0001, sub -> sum=0x7FFF, carry=1, ovf=1.
- Backpressure: hold done_ready_in=0 for 5 cycles while pulsing start_valid_in with new operands. Required: sum_out stable, start_ready_out=0, no new accept. Release done_ready_in and check the next start is accepted the cycle after.
- Reset mid-op: assert rst_n_in=0 after 2 RUN cycles. Required: outputs go to 0 immediately, busy_out=0. After release, start_ready_out=1 and a fresh 0x1234+0x4321 gives 0x5555.
